csr_dbg_arbiter: RTL and testbench

- Shares the single CSR read/write port of the privileged unit between two requesters: the core pipeline (M stage) and an external debug/abstract-command requester.
- The core always has priority. A debug access is slotted into a cycle where the M stage issues no CSR operation and takes no trap.
- Debug read data is captured one cycle later, matching the W-stage CSR read value timing, and returned over a valid/ready response channel.

---
 rtl/csr_dbg_arbiter.sv | 166 ++++++++++++++++
 tb/tb_csr_dbg_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_dbg_arbiter.sv
// csr_dbg_arbiter
// Shares the privileged unit's single CSR read/write port between the core
// M stage (always wins) and an external debug / abstract-command requester.
// One debug request is outstanding at a time; it is slotted into the first
// cycle in which the M stage issues no CSR op and takes no trap. Read data
// is captured the cycle after the access and returned on a valid/ready
// response channel.
//
// Optional build macro: CSRDBG_STARVE_EN
//   When defined, an 8-bit wait counter tracks blocked WAIT cycles and
//   raises StallCoreReq once it reaches STARVE_LIMIT, asking the core for a
//   CSR-free bubble. When undefined, StallCoreReq is tied low and a debug
//   request may wait indefinitely.
module csr_dbg_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    // core M-stage status
    input  logic            CSRReadM,
    input  logic            CSRWriteM,
    input  logic            InstrValidM,
    input  logic            TrapM,
    // debug request channel
    input  logic            DbgReqValid,
    output logic            DbgReqReady,
    input  logic            DbgReqWrite,
    input  logic [11:0]     DbgReqAdr,
    input  logic [XLEN-1:0] DbgReqWData,
    // debug response channel
    output logic            DbgRspValid,
    input  logic            DbgRspReady,
    output logic [XLEN-1:0] DbgRspRData,
    output logic            DbgRspErr,
    // CSR port side
    output logic            CSRSelDbg,
    output logic            CSRDbgReadEn,
    output logic            CSRDbgWriteEn,
    output logic [11:0]     CSRDbgAdr,
    output logic [XLEN-1:0] CSRDbgWData,
    input  logic [XLEN-1:0] CSRDbgRData,
    input  logic            CSRDbgIllegal,
    // forced-slot request towards the core
    output logic            StallCoreReq
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;

    // latched request
    logic            r_write;
    logic [11:0]     r_adr;
    logic [XLEN-1:0] r_wdata;

    // latched response
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_slot_free;
    logic            w_accept;
    logic            w_access;
    logic [XLEN-1:0] w_capture_data;

    // The port is free for debug only when the M stage has no live CSR op
    // and no trap is being taken this cycle.
    assign w_slot_free = ~TrapM & ~(InstrValidM & (CSRReadM | CSRWriteM));
    assign w_accept    = (r_state == S_IDLE) & DbgReqValid;
    assign w_access    = (r_state == S_WAIT) & w_slot_free;

    // Writes return zero data; reads return whatever the CSR file produced.
    assign w_capture_data = r_write ? '0 : CSRDbgRData;

    // Next-state selection for the single-outstanding-request sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (DbgReqValid) w_state_next = S_WAIT;
            S_WAIT:    if (w_slot_free) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_RESP;
            S_RESP:    if (DbgRspReady) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // State register; reset drops any in-flight request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the request fields when it is accepted in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= DbgReqWrite;
            r_adr   <= DbgReqAdr;
            r_wdata <= DbgReqWData;
        end
    end

    // Capture read data and the illegal flag the cycle after the access;
    // both are then held through RESP until the handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            r_rdata <= w_capture_data;
            r_err   <= CSRDbgIllegal;
        end
    end

    // Outputs are forced low while reset is held so nothing leaks out
    // of a half-finished transaction.
    assign DbgReqReady   = ~reset & (r_state == S_IDLE);
    assign DbgRspValid   = ~reset & (r_state == S_RESP);
    assign DbgRspRData   = r_rdata;
    assign DbgRspErr     = r_err;
    assign CSRSelDbg     = ~reset & w_access;
    assign CSRDbgReadEn  = ~reset & w_access & ~r_write;
    assign CSRDbgWriteEn = ~reset & w_access & r_write;
    assign CSRDbgAdr     = r_adr;
    assign CSRDbgWData   = r_wdata;

`ifdef CSRDBG_STARVE_EN
    // Clamp the threshold to what the 8-bit counter can represent.
    localparam int         LP_LIMIT_SAT = (STARVE_LIMIT > 255) ? 255 :
                                          ((STARVE_LIMIT < 0) ? 0 : STARVE_LIMIT);
    localparam logic [7:0] LP_LIMIT     = LP_LIMIT_SAT[7:0];

    logic [7:0] r_wait_cnt;

    // Count blocked WAIT cycles; zero whenever not waiting so the count
    // starts fresh on every entry to WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if ((r_state != S_WAIT) || w_slot_free) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Held until the access cycle itself, after which the state leaves WAIT.
    assign StallCoreReq = ~reset & (r_state == S_WAIT) & (r_wait_cnt >= LP_LIMIT);
`else
    // Threshold is meaningless without the counter.
    localparam int LP_STARVE_UNUSED = STARVE_LIMIT;

    assign StallCoreReq = 1'b0;
`endif

endmodule

// File: tb/tb_csr_dbg_arbiter.sv
// tb_csr_dbg_arbiter
// Directed table of per-cycle vectors, hand-written sequences for the
// multi-cycle corners (response back-pressure, reset in RESP, starvation
// when CSRDBG_STARVE_EN is defined) and a randomized run checked against a
// transaction-level reference model.
module tb_csr_dbg_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            CSRReadM, CSRWriteM, InstrValidM, TrapM;
    logic            DbgReqValid, DbgReqReady, DbgReqWrite;
    logic [11:0]     DbgReqAdr;
    logic [XLEN-1:0] DbgReqWData;
    logic            DbgRspValid, DbgRspReady;
    logic [XLEN-1:0] DbgRspRData;
    logic            DbgRspErr;
    logic            CSRSelDbg, CSRDbgReadEn, CSRDbgWriteEn;
    logic [11:0]     CSRDbgAdr;
    logic [XLEN-1:0] CSRDbgWData, CSRDbgRData;
    logic            CSRDbgIllegal;
    logic            StallCoreReq;

    int checks = 0;
    int errors = 0;

    csr_dbg_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .CSRReadM     (CSRReadM),
        .CSRWriteM    (CSRWriteM),
        .InstrValidM  (InstrValidM),
        .TrapM        (TrapM),
        .DbgReqValid  (DbgReqValid),
        .DbgReqReady  (DbgReqReady),
        .DbgReqWrite  (DbgReqWrite),
        .DbgReqAdr    (DbgReqAdr),
        .DbgReqWData  (DbgReqWData),
        .DbgRspValid  (DbgRspValid),
        .DbgRspReady  (DbgRspReady),
        .DbgRspRData  (DbgRspRData),
        .DbgRspErr    (DbgRspErr),
        .CSRSelDbg    (CSRSelDbg),
        .CSRDbgReadEn (CSRDbgReadEn),
        .CSRDbgWriteEn(CSRDbgWriteEn),
        .CSRDbgAdr    (CSRDbgAdr),
        .CSRDbgWData  (CSRDbgWData),
        .CSRDbgRData  (CSRDbgRData),
        .CSRDbgIllegal(CSRDbgIllegal),
        .StallCoreReq (StallCoreReq)
    );

    always #5 clk = ~clk;

    // one cycle of stimulus plus the outputs expected in that cycle
    typedef struct {
        bit          rv;
        bit          rw;
        logic [11:0] adr;
        logic [63:0] wd;
        int          cc;     // 0 idle, 1 valid csr write, 2 trap, 3 csr read w/o valid, 4 valid csr read
        bit          rr;
        logic [63:0] rd;
        bit          ill;
        bit          er;     // expected DbgReqReady
        bit          es;     // expected CSRSelDbg
        bit          ev;     // expected DbgRspValid
        logic [63:0] erdata;
        bit          eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rv, bit rw, logic [11:0] adr, logic [63:0] wd, int cc,
                                bit rr, logic [63:0] rd, bit ill,
                                bit er, bit es, bit ev, logic [63:0] erdata, bit eerr);
        vec_t v;
        v.rv = rv; v.rw = rw; v.adr = adr; v.wd = wd; v.cc = cc;
        v.rr = rr; v.rd = rd; v.ill = ill;
        v.er = er; v.es = es; v.ev = ev; v.erdata = erdata; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_core(input int cc);
        CSRReadM    = (cc == 3) || (cc == 4);
        CSRWriteM   = (cc == 1);
        InstrValidM = (cc == 1) || (cc == 4);
        TrapM       = (cc == 2);
    endtask

    task automatic idle_inputs();
        DbgReqValid = 0; DbgReqWrite = 0; DbgReqAdr = '0; DbgReqWData = '0;
        DbgRspReady = 0; CSRDbgRData = '0; CSRDbgIllegal = 0;
        set_core(0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    // reference model state (transaction level)
    bit          m_busy, m_accessed, m_w;
    int          m_since;
    logic [11:0] m_adr;
    logic [63:0] m_wd, m_rdata;
    bit          m_err;

    logic [11:0] last_adr;
    logic [63:0] last_wd;
    bit          last_w;

    initial begin
        reset = 1;
        idle_inputs();

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", DbgReqReady, 0);
        chk("rst_rsp_valid", DbgRspValid, 0);
        chk("rst_rsp_rdata", DbgRspRData, 0);
        chk("rst_sel", CSRSelDbg, 0);
        chk("rst_adr", CSRDbgAdr, 0);
        chk("rst_stall", StallCoreReq, 0);
        reset = 0;

        // read 0x300 on an idle core: access cycle 1, response cycle 3
        vecs.push_back(mk(1,0,12'h300,0,0, 0,0,0, 1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0, 0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,64'h8000_0000_0000_1888,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       1,0,0, 0,0,1,64'h8000_0000_0000_1888,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0, 1,0,0,0,0));
        // write 0x340: single write strobe, zero read data
        vecs.push_back(mk(1,1,12'h340,64'hDEAD_BEEF,0, 0,0,0, 1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,64'h5555,0, 0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,64'h1234,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       1,0,0, 0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0, 1,0,0,0,0));
        // core CSR write for 5 WAIT cycles; access on the 6th
        vecs.push_back(mk(1,0,12'h7B0,0,1, 0,0,0, 1,0,0,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0,0,1,   0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0, 0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,64'hABCD,1, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0, 0,0,1,64'hABCD,1));
        vecs.push_back(mk(0,0,0,0,0,       1,0,0, 0,0,1,64'hABCD,1));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0, 1,0,0,0,0));
        // trap in the only CSR-free cycle defers the access
        vecs.push_back(mk(1,0,12'h341,0,1, 0,0,0, 1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,       0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,2,       0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,4,       0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,3,       0,0,0, 0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,64'h42,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       1,0,0, 0,0,1,64'h42,0));
        // back-to-back write accepted right after the handshake
        vecs.push_back(mk(1,1,12'h305,64'h11,0, 0,0,0, 1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0, 0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       0,64'h99,1, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       1,0,0, 0,0,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0, 1,0,0,0,0));

        last_adr = '0; last_wd = '0; last_w = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            DbgReqValid = vecs[i].rv; DbgReqWrite = vecs[i].rw;
            DbgReqAdr = vecs[i].adr; DbgReqWData = vecs[i].wd;
            DbgRspReady = vecs[i].rr; CSRDbgRData = vecs[i].rd;
            CSRDbgIllegal = vecs[i].ill;
            set_core(vecs[i].cc);
            #1;
            chk($sformatf("v%0d_req_ready", i), DbgReqReady, vecs[i].er);
            chk($sformatf("v%0d_sel", i), CSRSelDbg, vecs[i].es);
            chk($sformatf("v%0d_rd_en", i), CSRDbgReadEn, vecs[i].es & ~last_w);
            chk($sformatf("v%0d_wr_en", i), CSRDbgWriteEn, vecs[i].es & last_w);
            chk($sformatf("v%0d_rsp_valid", i), DbgRspValid, vecs[i].ev);
            if (vecs[i].es) begin
                chk($sformatf("v%0d_adr", i), CSRDbgAdr, last_adr);
                chk($sformatf("v%0d_wdata", i), CSRDbgWData, last_wd);
            end
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_rdata", i), DbgRspRData, vecs[i].erdata);
                chk($sformatf("v%0d_err", i), DbgRspErr, vecs[i].eerr);
            end
            if (vecs[i].rv && vecs[i].er) begin
                last_adr = vecs[i].adr; last_wd = vecs[i].wd; last_w = vecs[i].rw;
            end
        end

        // response back-pressure for 4 cycles, then reset during RESP
        @(negedge clk);
        idle_inputs();
        DbgReqValid = 1; DbgReqAdr = 12'h306;
        @(negedge clk);
        DbgReqValid = 0;
        @(negedge clk);
        CSRDbgRData = 64'h77; CSRDbgIllegal = 1;
        @(negedge clk);
        CSRDbgRData = 64'hFFFF; CSRDbgIllegal = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("hold_valid", DbgRspValid, 1);
            chk("hold_rdata", DbgRspRData, 64'h77);
            chk("hold_err", DbgRspErr, 1);
            chk("hold_req_ready", DbgReqReady, 0);
            @(negedge clk);
        end
        reset = 1;
        @(negedge clk);
        #1;
        chk("rstresp_valid", DbgRspValid, 0);
        chk("rstresp_rdata", DbgRspRData, 0);
        chk("rstresp_err", DbgRspErr, 0);
        chk("rstresp_adr", CSRDbgAdr, 0);
        chk("rstresp_sel", CSRSelDbg, 0);
        chk("rstresp_req_ready", DbgReqReady, 0);
        @(negedge clk);
        reset = 0;
        #1;
        chk("post_rst_idle_ready", DbgReqReady, 1);
        chk("post_rst_valid", DbgRspValid, 0);

`ifdef CSRDBG_STARVE_EN
        // starvation: limit 4, core busy until the requested bubble
        @(negedge clk);
        idle_inputs();
        set_core(1);
        DbgReqValid = 1; DbgReqAdr = 12'h300;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            DbgReqValid = 0;
            #1;
            chk($sformatf("starve_sel_%0d", k), CSRSelDbg, 0);
            chk($sformatf("starve_stall_%0d", k), StallCoreReq, (k >= 5));
        end
        @(negedge clk);
        set_core(0);
        #1;
        chk("starve_bubble_sel", CSRSelDbg, 1);
        chk("starve_bubble_stall", StallCoreReq, 1);
        @(negedge clk);
        CSRDbgRData = 64'h99; CSRDbgIllegal = 1;
        #1;
        chk("starve_stall_drop", StallCoreReq, 0);
        @(negedge clk);
        DbgRspReady = 1; CSRDbgIllegal = 0;
        #1;
        chk("starve_valid", DbgRspValid, 1);
        chk("starve_err", DbgRspErr, 1);
        chk("starve_rdata", DbgRspRData, 64'h99);
`endif

        // randomized run against a transaction-level model
        do_reset();
        m_busy = 0; m_accessed = 0; m_since = 0; m_w = 0;
        m_adr = '0; m_wd = '0; m_rdata = '0; m_err = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit free, exp_sel, exp_valid;
            @(negedge clk);
            DbgReqValid   = ($urandom_range(0, 1) == 1);
            DbgReqWrite   = ($urandom_range(0, 1) == 1);
            DbgReqAdr     = 12'($urandom);
            DbgReqWData   = {$urandom, $urandom};
            DbgRspReady   = ($urandom_range(0, 2) != 0);
            CSRDbgRData   = {$urandom, $urandom};
            CSRDbgIllegal = ($urandom_range(0, 3) == 0);
            CSRReadM      = ($urandom_range(0, 2) == 0);
            CSRWriteM     = ($urandom_range(0, 2) == 0);
            InstrValidM   = ($urandom_range(0, 1) == 1);
            TrapM         = ($urandom_range(0, 7) == 0);
            #1;
            free      = !TrapM && !(InstrValidM && (CSRReadM || CSRWriteM));
            exp_sel   = m_busy && !m_accessed && free;
            exp_valid = m_accessed && (m_since >= 2);
            chk("rnd_req_ready", DbgReqReady, !m_busy);
            chk("rnd_sel", CSRSelDbg, exp_sel);
            chk("rnd_rd_en", CSRDbgReadEn, exp_sel && !m_w);
            chk("rnd_wr_en", CSRDbgWriteEn, exp_sel && m_w);
            chk("rnd_rsp_valid", DbgRspValid, exp_valid);
`ifndef CSRDBG_STARVE_EN
            chk("rnd_stall", StallCoreReq, 0);
`endif
            if (exp_sel) begin
                chk("rnd_adr", CSRDbgAdr, m_adr);
                chk("rnd_wdata", CSRDbgWData, m_wd);
            end
            if (exp_valid) begin
                chk("rnd_rdata", DbgRspRData, m_rdata);
                chk("rnd_err", DbgRspErr, m_err);
            end
            // advance model to reflect the coming clock edge
            if (!m_busy) begin
                if (DbgReqValid) begin
                    m_busy = 1; m_accessed = 0;
                    m_w = DbgReqWrite; m_adr = DbgReqAdr; m_wd = DbgReqWData;
                end
            end else if (!m_accessed) begin
                if (free) begin
                    m_accessed = 1; m_since = 1;
                end
            end else if (m_since == 1) begin
                m_rdata = m_w ? 64'd0 : CSRDbgRData;
                m_err   = CSRDbgIllegal;
                m_since = 2;
            end else if (DbgRspReady) begin
                m_busy = 0; m_accessed = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
